// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The checksum state is only reachable with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int LEN_BYTES = 2;
  localparam int CHK_W = 8;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the core meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  loader_state_t state, state_n;

  logic [AW-1:0]    cnt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_n;
  logic             acc;
  logic             last;
  logic             len_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CHK_W-1:0] sum;
`endif

  assign acc     = rx_valid && rx_ready;
  assign len_n   = {len[LEN_W-1:8], rx_data};
  assign len_bad = (len_n == '0) ||
                   (len_n > LEN_W'(MEM_BYTES));
  assign last    = (LEN_W'(cnt) == len - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Status outputs decode straight from state, so they
  // move on the same edge that launches the last write.
  always_comb begin
    state_n   = state;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    core_hold = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) state_n = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (acc) state_n = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (acc) state_n = len_bad ? ERR : DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (acc && last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end
      end
      CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (acc) state_n = (rx_data == sum) ? DONE : ERR;
`else
        state_n = ERR;
`endif
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) state_n = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_n = LEN_HI;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      len     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (acc) begin
        unique case (state)
          LEN_HI: len <= LEN_W'({rx_data, 8'h00});
          LEN_LO: begin
            len <= len_n;
            cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum <= '0;
`endif
          end
          DATA: begin
            wr_en   <= 1'b1;
            wr_addr <= 32'(cnt);
            wr_data <= rx_data;
            cnt     <= cnt + AW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum     <= sum + rx_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table plus reset and checksum sequences.
// Expectations follow IMEM_LOADER_CHECKSUM_EN when it is defined.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(
    .MEM_BYTES(128),
    .LEN_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .core_hold(core_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:127];
  int wcount = 0;

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[6:0]] <= wr_data;
      wcount++;
    end
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic       st;
    logic       rv;
    logic [7:0] d;
    logic       rdy;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       dn;
    logic       er;
    logic       hd;
    logic       by;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    input logic st, input logic rv, input logic [7:0] d,
    input logic rdy, input logic we,
    input logic [7:0] addr, input logic [7:0] wd,
    input logic dn, input logic er,
    input logic hd, input logic by);
    vec_t v;
    v.st = st; v.rv = rv; v.d = d;
    v.rdy = rdy; v.we = we; v.addr = addr; v.wd = wd;
    v.dn = dn; v.er = er; v.hd = hd; v.by = by;
    tv.push_back(v);
  endfunction

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      start    = tv[i].st;
      rx_valid = tv[i].rv;
      rx_data  = tv[i].d;
      #1;
      check($sformatf("vec%0d", i),
        {rx_ready, wr_en, done, error, core_hold, busy,
         wr_en ? wr_addr : 32'h0, wr_en ? wr_data : 8'h00},
        {tv[i].rdy, tv[i].we, tv[i].dn, tv[i].er,
         tv[i].hd, tv[i].by,
         tv[i].we ? {24'h0, tv[i].addr} : 32'h0,
         tv[i].we ? tv[i].wd : 8'h00});
    end
  endtask

  task automatic drive(input logic st, input logic rv,
                       input logic [7:0] d);
    @(negedge clk);
    start    = st;
    rx_valid = rv;
    rx_data  = d;
  endtask

  function automatic logic [5:0] flags();
    return {rx_ready, wr_en, done, error, core_hold, busy};
  endfunction

  int snap;

  initial begin
    // st rv d | rdy we addr wd | dn er hd by
    add(0, 1, 8'h55, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h04, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h13, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h05, 1, 1, 0, 8'h13, 0, 0, 1, 1);
    add(0, 1, 8'hA0, 1, 1, 1, 8'h05, 0, 0, 1, 1);
    add(0, 1, 8'h00, 1, 1, 2, 8'hA0, 0, 0, 1, 1);
    add(0, 1, CK ? 8'hB8 : 8'hFF,
        CK, 1, 3, 8'h00, !CK, 0, CK, CK);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    // zero length, then oversize length
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h12, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h81, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    // length 3 with gaps and a stray start
    add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h03, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'hAA, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 1, 0, 8'hAA, 0, 0, 1, 1);
    add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'hBB, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 1, 1, 8'hBB, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'hCC, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 8'h00, CK, 1, 2, 8'hCC, !CK, 0, CK, CK);
    add(0, 1, 8'h31, CK, 0, 0, 8'h00, !CK, 0, CK, CK);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0);

    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_flags", 64'(flags()), 64'(6'b000010));
    check("reset_wr", {wr_addr, wr_data}, 64'h0);
    rst = 1'b0;

    run(0, 10);
    check("fetch0", {mem[0], mem[1], mem[2], mem[3]},
          64'h1305A000);
    run(10, 20);
    snap = wcount;
    run(20, tv.size());
    check("gap_writes", 64'(wcount - snap), 64'd3);
    check("fetch_gap", {mem[0], mem[1], mem[2], mem[3]},
          64'hAABBCC00);

    // reset in the middle of a length-8 load
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h08);
    drive(0, 1, 8'h11);
    drive(0, 1, 8'h22);
    drive(0, 0, 8'h00);
    #1;
    check("pre_rst_wr", {wr_en, wr_addr, wr_data},
          {1'b1, 32'h1, 8'h22});
    rst = 1'b1;
    #1;
    check("mid_rst_flags", 64'(flags()), 64'(6'b000010));
    check("mid_rst_addr", 64'(wr_addr), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h01);
    drive(0, 1, 8'h77);
    drive(0, CK, 8'h77);
    #1;
    check("restart_wr", {wr_en, wr_addr, wr_data},
          {1'b1, 32'h0, 8'h77});
    drive(0, 0, 8'h00);
    #1;
    check("restart_done", 64'(flags()), 64'(6'b001000));

    // checksum match, then mismatch
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h02);
    drive(0, 1, 8'h10);
    drive(0, 1, 8'h20);
    drive(0, 1, 8'h30);
    drive(0, 0, 8'h00);
    #1;
    check("sum_ok", 64'({done, error, core_hold}), 64'(3'b100));
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h02);
    drive(0, 1, 8'h10);
    drive(0, 1, 8'h20);
    drive(0, 1, 8'h31);
    drive(0, 0, 8'h00);
    #1;
    check("sum_bad", 64'({done, error, core_hold}),
          CK ? 64'(3'b011) : 64'(3'b100));
    check("sum_bad_mem", 64'({mem[0], mem[1]}), 64'h1020);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
